// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for one 4x4 systolic array: walks m/n/k tiles, strobes flush/sync, hands results to writeback.
// Optional RUN watchdog enabled by defining SA_WATCHDOG_EN.
module sa_tile_scheduler #(
    parameter int unsigned TILE_IDX_W = 4,
    parameter int unsigned WD_LIMIT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TILE_IDX_W-1:0] cfg_m_tiles,
    input  logic [TILE_IDX_W-1:0] cfg_n_tiles,
    input  logic [TILE_IDX_W-1:0] cfg_k_tiles,
    output logic                  busy,
    output logic                  finish,
    output logic                  op_req,
    input  logic                  op_ack,
    output logic [TILE_IDX_W-1:0] op_m,
    output logic [TILE_IDX_W-1:0] op_n,
    output logic [TILE_IDX_W-1:0] op_k,
    output logic                  sa_reset_n,
    output logic                  sa_flush_n,
    input  logic                  sa_done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [TILE_IDX_W-1:0] res_m,
    output logic [TILE_IDX_W-1:0] res_n,
    output logic                  err
);

    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FLUSH, S_SYNC, S_RUN, S_WB
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [TILE_IDX_W-1:0] r_cfg_m, r_cfg_n, r_cfg_k;
    logic [TILE_IDX_W-1:0] w_cfg_m_nxt, w_cfg_n_nxt, w_cfg_k_nxt;
    logic [TILE_IDX_W-1:0] r_m, r_n, r_k, w_m_nxt, w_n_nxt, w_k_nxt;
    logic [TILE_IDX_W-1:0] r_res_m, r_res_n, w_res_m_nxt, w_res_n_nxt;
    logic                  r_busy, r_finish, r_op_req, r_sa_reset_n, r_sa_flush_n;
    logic                  r_res_valid, r_err;
    logic                  w_finish_nxt, w_err_nxt, w_wd_fire;
`ifdef SA_WATCHDOG_EN
    logic [WD_W-1:0]       r_wd_cnt, w_wd_cnt_nxt;
`endif

    // Next-state and next-output logic; outputs follow the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_cfg_m_nxt  = r_cfg_m;
        w_cfg_n_nxt  = r_cfg_n;
        w_cfg_k_nxt  = r_cfg_k;
        w_m_nxt      = r_m;
        w_n_nxt      = r_n;
        w_k_nxt      = r_k;
        w_res_m_nxt  = r_res_m;
        w_res_n_nxt  = r_res_n;
        w_finish_nxt = 1'b0;
        w_err_nxt    = r_err;
        w_wd_fire    = 1'b0;
`ifdef SA_WATCHDOG_EN
        w_wd_cnt_nxt = r_wd_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start && !r_err) begin
                    w_cfg_m_nxt = cfg_m_tiles;
                    w_cfg_n_nxt = cfg_n_tiles;
                    w_cfg_k_nxt = cfg_k_tiles;
                    w_m_nxt     = '0;
                    w_n_nxt     = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (op_ack) w_state_nxt = (r_k == '0) ? S_FLUSH : S_SYNC;
            end
            S_FLUSH, S_SYNC: begin
`ifdef SA_WATCHDOG_EN
                w_wd_cnt_nxt = '0;
`endif
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (sa_done) begin
                    if (r_k == r_cfg_k) begin
                        w_res_m_nxt = r_m;
                        w_res_n_nxt = r_n;
                        w_state_nxt = S_WB;
                    end else begin
                        w_k_nxt     = r_k + TILE_IDX_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
`ifdef SA_WATCHDOG_EN
                else if (r_wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_wd_fire   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + WD_W'(1);
                end
`endif
            end
            S_WB: begin
                if (res_ready) begin
                    w_k_nxt = '0;
                    if (r_n == r_cfg_n) begin
                        w_n_nxt = '0;
                        w_m_nxt = r_m + TILE_IDX_W'(1);
                    end else begin
                        w_n_nxt = r_n + TILE_IDX_W'(1);
                    end
                    if ((r_m == r_cfg_m) && (r_n == r_cfg_n)) begin
                        w_finish_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt  = S_FETCH;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cfg_m      <= '0;
            r_cfg_n      <= '0;
            r_cfg_k      <= '0;
            r_m          <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_res_m      <= '0;
            r_res_n      <= '0;
            r_busy       <= 1'b0;
            r_finish     <= 1'b0;
            r_op_req     <= 1'b0;
            r_sa_reset_n <= 1'b0;
            r_sa_flush_n <= 1'b1;
            r_res_valid  <= 1'b0;
            r_err        <= 1'b0;
`ifdef SA_WATCHDOG_EN
            r_wd_cnt     <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cfg_m      <= w_cfg_m_nxt;
            r_cfg_n      <= w_cfg_n_nxt;
            r_cfg_k      <= w_cfg_k_nxt;
            r_m          <= w_m_nxt;
            r_n          <= w_n_nxt;
            r_k          <= w_k_nxt;
            r_res_m      <= w_res_m_nxt;
            r_res_n      <= w_res_n_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_finish     <= w_finish_nxt;
            r_op_req     <= (w_state_nxt == S_FETCH);
            r_sa_reset_n <= (w_state_nxt != S_SYNC) && !w_wd_fire;
            r_sa_flush_n <= (w_state_nxt != S_FLUSH);
            r_res_valid  <= (w_state_nxt == S_WB);
            r_err        <= w_err_nxt;
`ifdef SA_WATCHDOG_EN
            r_wd_cnt     <= w_wd_cnt_nxt;
`endif
        end
    end

    assign busy       = r_busy;
    assign finish     = r_finish;
    assign op_req     = r_op_req;
    assign op_m       = r_m;
    assign op_n       = r_n;
    assign op_k       = r_k;
    assign sa_reset_n = r_sa_reset_n;
    assign sa_flush_n = r_sa_flush_n;
    assign res_valid  = r_res_valid;
    assign res_m      = r_res_m;
    assign res_n      = r_res_n;
    assign err        = r_err;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Bench for sa_tile_scheduler: queue-based job model plus a behavioural array with accumulators.
module tb_sa_tile_scheduler;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          reset, start, op_ack, sa_done, res_ready;
    logic [TW-1:0] cfg_m_tiles, cfg_n_tiles, cfg_k_tiles;
    logic          busy, finish, op_req, sa_reset_n, sa_flush_n, res_valid, err;
    logic [TW-1:0] op_m, op_n, op_k, res_m, res_n;

    always #5 clk = ~clk;

    sa_tile_scheduler #(.TILE_IDX_W(TW), .WD_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
        .busy(busy), .finish(finish), .op_req(op_req), .op_ack(op_ack),
        .op_m(op_m), .op_n(op_n), .op_k(op_k),
        .sa_reset_n(sa_reset_n), .sa_flush_n(sa_flush_n), .sa_done(sa_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_m(res_m), .res_n(res_n),
        .err(err)
    );

    int checks = 0, failures = 0;
    int q_fetch[$], q_strobe[$], q_res[$], q_acc[$];
    int n_flush = 0, n_sync = 0, n_res = 0, n_fin = 0, n_wdrst = 0;
    int cyc = 0, strobe_cyc = 0, err_cyc = 0;
    int acc = 0, cap = 0, cnt = 0, stall_req = 0, stall_left = 0;
    bit withhold = 0, spurious = 0;
    logic prev_op_req = 1'b0, prev_res_valid = 1'b0, prev_err = 1'b0;
    logic [TW-1:0] hold_m = '0, hold_n = '0;

    // Operand value a pass contributes to output tile (m,n) at inner index k.
    function automatic int tval(input int m, input int n, input int k);
        return 100 * m + 10 * n + k + 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected job: m outer, n middle, k inner; k==0 pass flushes, later passes accumulate.
    task automatic plan(input int mt, input int nt, input int kt);
        int s;
        q_fetch.delete(); q_strobe.delete(); q_res.delete(); q_acc.delete();
        for (int m = 0; m <= mt; m++)
            for (int n = 0; n <= nt; n++) begin
                s = 0;
                for (int k = 0; k <= kt; k++) begin
                    q_fetch.push_back(m * 256 + n * 16 + k);
                    q_strobe.push_back((k == 0) ? 1 : 0);
                    s += tval(m, n, k);
                end
                q_res.push_back(m * 16 + n);
                q_acc.push_back(s);
            end
    endtask

    task automatic launch(input int m, input int n, input int k);
        plan(m, n, k);
        n_flush = 0; n_sync = 0; n_res = 0; n_fin = 0;
        @(posedge clk); #1;
        cfg_m_tiles = TW'(m); cfg_n_tiles = TW'(n); cfg_k_tiles = TW'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int m, input int n, input int k, input int stall, input bit poke,
                           input int e_flush, input int e_sync, input int e_res, input int e_acc);
        int t;
        stall_req = stall;
        launch(m, n, k);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1; start = 1'b1; cfg_m_tiles = '0; cfg_n_tiles = '0; cfg_k_tiles = '0;
            @(posedge clk); #1; start = 1'b0;
        end
        t = 0;
        while (n_fin == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("finish_count", n_fin, 1);
        chk("flush_pulses", n_flush, e_flush);
        chk("sync_pulses", n_sync, e_sync);
        chk("result_tiles", n_res, e_res);
        chk("last_tile_value", acc, e_acc);
        chk("fetch_leftover", q_fetch.size(), 0);
        stall_req = 0;
    endtask

    // Environment: operand buffer ack, array model (done 11 cycles after strobe), writeback ready.
    initial begin
        op_ack = 1'b0; sa_done = 1'b0; res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            op_ack  = op_req;
            sa_done = spurious;
            if (reset) begin
                cnt = 0;
            end else if (busy && (!sa_flush_n || !sa_reset_n)) begin
                if (!sa_flush_n) acc = 0;
                cap = tval(int'(op_m), int'(op_n), int'(op_k));
                cnt = 11;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !withhold) begin
                    sa_done = 1'b1;
                    acc += cap;
                end
            end
            if (!res_valid) begin
                stall_left = stall_req;
                res_ready  = 1'b0;
            end else if (stall_left > 0) begin
                stall_left--;
                res_ready = 1'b0;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // Compare process: every meaningful output event is checked against the model queues.
    always @(negedge clk) begin : cmp
        int e;
        cyc++;
        if (!reset) begin
            if (op_req && !prev_op_req) begin
                if (q_fetch.size() > 0) begin
                    e = q_fetch.pop_front();
                    chk("fetch_index", int'(op_m) * 256 + int'(op_n) * 16 + int'(op_k), e);
                end else chk("fetch_unexpected", 1, 0);
            end
            if (busy && (!sa_flush_n || !sa_reset_n)) begin
                strobe_cyc = cyc;
                if (!sa_flush_n) n_flush++; else n_sync++;
                chk("strobe_exclusive", int'(sa_flush_n) + int'(sa_reset_n), 1);
                if (q_strobe.size() > 0) begin
                    e = q_strobe.pop_front();
                    chk("strobe_kind", (!sa_flush_n) ? 1 : 0, e);
                end else chk("strobe_unexpected", 1, 0);
            end
            if (!busy && !sa_reset_n) n_wdrst++;
            if (res_valid) begin
                if (prev_res_valid) begin
                    chk("wb_hold_index", int'(res_m) * 16 + int'(res_n), int'(hold_m) * 16 + int'(hold_n));
                    chk("wb_quiet", int'({op_req, sa_flush_n, sa_reset_n}), 3);
                end
                hold_m = res_m;
                hold_n = res_n;
                if (res_ready) begin
                    n_res++;
                    if (q_res.size() > 0) begin
                        e = q_res.pop_front();
                        chk("res_index", int'(res_m) * 16 + int'(res_n), e);
                        e = q_acc.pop_front();
                        chk("res_value", acc, e);
                    end else chk("res_unexpected", 1, 0);
                end
            end
            if (finish) begin
                n_fin++;
                chk("finish_idle", int'(busy), 0);
                chk("finish_pending", q_res.size(), 0);
            end
            if (err && !prev_err) begin
                err_cyc = cyc;
                chk("wd_fire_outputs", int'({busy, sa_reset_n}), 0);
            end
`ifndef SA_WATCHDOG_EN
            chk("err_low", int'(err), 0);
`endif
        end
        prev_op_req    = op_req;
        prev_res_valid = res_valid;
        prev_err       = err;
    end

    initial begin
        int t;
        reset = 1'b1; start = 1'b0;
        cfg_m_tiles = '0; cfg_n_tiles = '0; cfg_k_tiles = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", int'({busy, finish, op_req, res_valid, err}), 0);
        chk("rst_strobes", int'({sa_flush_n, sa_reset_n}), 2);
        chk("rst_idx", int'({op_m, op_n, op_k, res_m, res_n}), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_sa_reset_n", int'(sa_reset_n), 1);

        // sa_done while idle must not start anything
        @(posedge clk); #1 spurious = 1'b1;
        repeat (2) @(posedge clk);
        #1 spurious = 1'b0;
        @(negedge clk);
        chk("spurious_done_idle", int'(busy), 0);

        run_job(0, 0, 0, 0, 1'b0, 1, 0, 1, 1);
        run_job(0, 0, 2, 0, 1'b0, 1, 2, 1, 6);
        run_job(1, 1, 0, 0, 1'b1, 4, 0, 4, 111);
        run_job(0, 1, 0, 5, 1'b0, 2, 0, 2, 11);

        // Reset in the middle of a 2x2x2 job
        launch(1, 1, 1);
        t = 0;
        while (n_sync < 1 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("midrun_reached", (n_sync >= 1) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrun_rst_ctrl", int'({busy, op_req, res_valid, finish}), 0);
        chk("midrun_rst_sa_reset_n", int'(sa_reset_n), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        run_job(1, 1, 1, 0, 1'b0, 4, 4, 4, 223);

`ifdef SA_WATCHDOG_EN
        withhold = 1'b1;
        n_wdrst = 0;
        launch(0, 0, 0);
        t = 0;
        while (!err && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("wd_err", int'(err), 1);
        chk("wd_latency", err_cyc - strobe_cyc, 17);
        chk("wd_reset_pulses", n_wdrst, 1);
        chk("wd_no_finish", n_fin, 0);
        withhold = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(negedge clk);
        chk("wd_start_refused", int'(busy), 0);
        chk("wd_err_sticky", int'(err), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
